// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the RV32 core.
// Loader state encoding, fixed instruction words and base opcodes.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_RUN,
    S_ERR
  } state_e;

  localparam logic [31:0] HALT_INSTR = 32'h00000073;
  localparam logic [31:0] NOP_INSTR  = 32'h00000013;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imem_loader_byte_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// word/word_valid are presented in the cycle the 4th byte is accepted.
module byte_word_assembler (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] shift_q, shift_d;

  // Lane count and shift-in; first byte ends up in bits [7:0].
  always_comb begin
    lane_d  = lane_q;
    shift_d = shift_q;
    if (clear) begin
      lane_d = 2'd0;
    end else if (accept) begin
      lane_d  = lane_q + 2'd1;
      shift_d = {byte_data, shift_q[31:8]};
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane_q  <= 2'd0;
      shift_q <= 32'd0;
    end else begin
      lane_q  <= lane_d;
      shift_q <= shift_d;
    end
  end

  assign word       = {byte_data, shift_q[31:8]};
  assign word_valid = accept && (lane_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Byte-streamed instruction memory with same-cycle fetch for the core.
// Holds the core in reset until a complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_INSTR
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       pc,
  output logic [31:0]       instr,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              cpu_resetn,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   load_count
);

  localparam int MEM_WORDS = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              asm_clr;
  logic              accept;
  logic              we;
  logic [31:0]       asm_word;
  logic              asm_valid;
  logic              fetch_ok;

  logic [31:0] mem [MEM_WORDS] = '{default: HALT_WORD};

  assign accept  = byte_valid && byte_ready;
  assign cnt_inc = cnt_q + {{ADDR_W{1'b0}}, 1'b1};

  byte_word_assembler u_asm (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (asm_clr),
    .accept     (accept),
    .byte_data  (byte_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  // Load sequencing: length header, then N data words, then run.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    asm_clr    = 1'b0;
    we         = 1'b0;
    byte_ready = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) begin
          state_d = S_LEN;
          asm_clr = 1'b1;
          cnt_d   = '0;
        end
      end
      S_LEN: begin
        byte_ready = 1'b1;
        if (asm_valid) begin
          if (asm_word == 32'd0) begin
            state_d = S_RUN;
          end else if (asm_word > 32'(MEM_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
            len_d   = asm_word[ADDR_W:0];
            ptr_d   = '0;
          end
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        if (asm_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    cpu_rst_d = (state_d == S_RUN);
  end

  // Control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      cpu_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      cpu_rst_q <= cpu_rst_d;
    end
  end

  // Word array write port; contents survive reset and later loads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[ptr_q] <= asm_word;
    end
  end

  assign fetch_ok = (state_q == S_RUN) &&
                    (pc[1:0] == 2'b00) &&
                    (pc[31:ADDR_W+2] == '0);

  assign instr      = fetch_ok ? mem[pc[ADDR_W+1:2]] : HALT_WORD;
  assign cpu_resetn = cpu_rst_q;
  assign load_done  = (state_q == S_RUN);
  assign load_err   = (state_q == S_ERR);
  assign load_count = cnt_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Instruction-side responder for the single-cycle RV32 core. It answers the core's PC with the instruction word combinationally, in the same cycle.
- The program is streamed in as bytes over a valid/ready byte channel and assembled into 32-bit little-endian words, which are written into an internal word array.
- The core is held in reset (via cpu_resetn) until a complete, well-formed image has been loaded.
- Sits between the host/UART byte source and the core's instr/PC/resetn pins.

Parameters:
ADDR_W, 8, word-address width; the array holds 2**ADDR_W words.
HALT_WORD, 32'h00000073, word returned for invalid fetches (SYSTEM opcode; the core stalls on it).

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
pc  input  32  byte address from the core
instr  output  32  instruction to the core, combinational from pc
load_start  input  1  single-cycle pulse; begins a new image load
byte_valid  input  1  byte_data is valid
byte_data  input  8  image byte
byte_ready  output  1  loader accepts a byte this cycle
cpu_resetn  output  1  registered, active-low reset to the core
load_done  output  1  high while in RUN
load_err  output  1  high while in ERR
load_count  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; byte lane counter, length, word pointer and load_count are cleared to 0.
  - cpu_resetn=0, load_done=0, load_err=0, byte_ready=0.
  - Array contents are NOT reset; they are preset to HALT_WORD at time zero for simulation.
- Image format: 4-byte little-endian word count N, followed by N instruction words, each little-endian (first byte goes to bits [7:0]).
- Byte transfer: a byte transfers on a clock edge where byte_valid && byte_ready. byte_ready=1 only in LEN and DATA.
- States:
  - IDLE: cpu_resetn=0. load_start -> LEN.
  - LEN: collect 4 bytes into the length register. On the 4th accepted byte:
    - N==0 -> RUN.
    - N > 2**ADDR_W -> ERR.
    - Otherwise -> DATA, with pointer=0.
  - DATA: collect 4 bytes into a shift register. On the 4th accepted byte, write the word to mem[pointer] and increment pointer and load_count. When the written word is the Nth, go to RUN.
  - RUN: cpu_resetn=1, load_done=1. load_start -> LEN; cpu_resetn drops to 0 on that same edge and load_count clears.
  - ERR: cpu_resetn=0, load_err=1. load_start -> LEN.
- load_start is ignored in LEN and DATA; a load cannot be aborted except by resetn.
- cpu_resetn is a flop. It is 1 exactly for the cycles in which the state is RUN, so the core sees its first released edge one cycle after the final byte is accepted.
- Lane counter: 2 bits, wraps 3->0 on each accepted 4th byte. It is cleared on entry to LEN.
- Fetch path (combinational, all states):
  - If state!=RUN, or pc[1:0]!=0, or pc[31:ADDR_W+2]!=0: instr=HALT_WORD.
  - Otherwise: instr=mem[pc[ADDR_W+1:2]].
- Words beyond N keep their previous contents; loads never clear the array.
- Write port is the only synchronous array access; there is no read-during-write hazard because fetch returns HALT_WORD outside RUN.
- Reset mid-load: the partial image remains in the array. After reset, the state is IDLE and the core is held in reset.

Decomposition:
- Shared package: state encoding (IDLE, LEN, DATA, RUN, ERR), the HALT_WORD and NOP (32'h00000013) constants, and the opcode localparams used by both the core and this loader.
- One sub-module is natural: byte_word_assembler, containing the lane counter, the 32-bit shift register and a word_valid pulse. It is reused for both the LEN and DATA phases.
- The FSM, array and fetch mux stay in imem_loader.

Test Plan:
1. Reset, then pc=0 -> instr=32'h00000073, cpu_resetn=0, byte_ready=0.
2. load_start, then bytes 02 00 00 00, 93 00 10 00, 93 80 10 00 -> RUN one cycle after the last byte; load_count=2, cpu_resetn=1. pc=0 -> 32'h00100093; pc=4 -> 32'h00108093; pc=8 -> the word left from the previous contents.
3. byte_valid toggled randomly during test 2 -> identical array contents; no byte is lost or duplicated.
4. Length bytes 01 01 00 00 (N=257, ADDR_W=8) -> ERR after the 4th byte; load_err=1, cpu_resetn=0, byte_ready=0, all fetches return HALT_WORD.
5. In RUN: pc=2 -> HALT_WORD; pc=32'h00000400 -> HALT_WORD; load_start -> cpu_resetn=0 on the next edge, load_count=0, byte_ready=1.
6. resetn pulsed low after 6 bytes of an N=3 load -> immediate IDLE, load_count=0. A fresh load of N=1 then completes, and mem[0] holds the new word.
